psec6_readout_serializer: RTL and testbench

//  Readout stage downstream of the SPI frontend. It consumes the decoded 7-bit address and a one-cycle address-valid strobe.
//  For channel-data addresses it latches the selected channel's counter word and shifts it MSB-first onto poci.
//  For register addresses it passes the register-file read bit (poci_spi) straight through.

---
 rtl/psec6_readout_pkg.sv | 24 ++
 rtl/psec6_piso_shift.sv | 60 ++++++
 rtl/psec6_readout_serializer.sv | 123 ++++++++++++
 tb/tb_psec6_readout_serializer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/psec6_readout_pkg.sv
// ============================================================================
// Module  : psec6_readout_pkg
// Brief   : Shared types and constants for the PSEC6 readout serializer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package psec6_readout_pkg;

    localparam logic [6:0] CH_BASE = 7'd16;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rd_state_t;

    typedef enum logic {
        SRC_REG = 1'b0,
        SRC_CH  = 1'b1
    } src_sel_t;

endpackage

`default_nettype wire

// File: rtl/psec6_piso_shift.sv
// ============================================================================
// Module  : psec6_piso_shift
// Brief   : Parallel-load, MSB-first shift register with down-counter and
//           last-bit flag. PSEC6_READOUT_PARITY_EN appends an even-parity bit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module psec6_piso_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             msb_o,
    output logic             last_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef PSEC6_READOUT_PARITY_EN
    localparam int SR_W     = WIDTH + 1;
    localparam int CNT_INIT = WIDTH;
    logic [SR_W-1:0] w_load_word;
    assign w_load_word = {data_i, ^data_i};
`else
    localparam int SR_W     = WIDTH;
    localparam int CNT_INIT = WIDTH - 1;
    logic [SR_W-1:0] w_load_word;
    assign w_load_word = data_i;
`endif

    logic [SR_W-1:0]  shift_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (clr_i) begin
            // Abort keeps the shifter contents; only the position is dropped.
            cnt_q   <= '0;
        end else if (load_i) begin
            shift_q <= w_load_word;
            cnt_q   <= CNT_W'(CNT_INIT);
        end else if (shift_i) begin
            shift_q <= {shift_q[SR_W-2:0], 1'b0};
            cnt_q   <= cnt_q - 1'b1;
        end
    end

    assign msb_o  = shift_q[SR_W-1];
    assign last_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/psec6_readout_serializer.sv
// ============================================================================
// Module  : psec6_readout_serializer
// Brief   : Channel-word / register readout onto poci with auto-advancing
//           burst reads. Option macro: PSEC6_READOUT_PARITY_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module psec6_readout_serializer
    import psec6_readout_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int WORD_W = 8
) (
    input  logic                     spi_clk_i,
    input  logic                     rst_i,
    input  logic                     cs_i,
    input  logic [6:0]               addr_i,
    input  logic                     addr_valid_i,
    input  logic                     poci_spi_i,
    input  logic [NUM_CH*WORD_W-1:0] ch_data_i,
    output logic                     poci_o,
    output logic [NUM_CH-1:0]        rd_ack_o,
    output logic                     busy_o
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    rd_state_t       state_q, state_d;
    src_sel_t        src_q, src_d;
    logic [CH_W-1:0] ch_ptr_q, ch_ptr_d;

    logic              w_is_ch;
    logic [CH_W-1:0]   w_addr_ch;
    logic [CH_W-1:0]   w_ch_next;
    logic [CH_W-1:0]   w_load_idx;
    logic [WORD_W-1:0] w_load_data;
    logic              w_last;
    logic              w_msb;
    logic              w_load;
    logic              w_shift;

    assign w_is_ch   = ({1'b0, addr_i} >= {1'b0, CH_BASE}) &&
                       ({1'b0, addr_i} <  ({1'b0, CH_BASE} + 8'(NUM_CH)));
    assign w_addr_ch = CH_W'(addr_i - CH_BASE);
    assign w_ch_next = (ch_ptr_q == CH_W'(NUM_CH - 1)) ? '0 : ch_ptr_q + 1'b1;

    // One mux serves both the initial load and the burst reload.
    assign w_load_idx  = (state_q == IDLE) ? w_addr_ch : w_ch_next;
    assign w_load_data = ch_data_i[w_load_idx*WORD_W +: WORD_W];

    assign w_load  = !cs_i && (((state_q == IDLE) && addr_valid_i && w_is_ch) ||
                               ((state_q == SHIFT) && w_last));
    assign w_shift = !cs_i && (state_q == SHIFT) && !w_last;

    psec6_piso_shift #(
        .WIDTH (WORD_W)
    ) u_piso (
        .clk_i   (spi_clk_i),
        .rst_i   (rst_i),
        .clr_i   (cs_i),
        .load_i  (w_load),
        .shift_i (w_shift),
        .data_i  (w_load_data),
        .msb_o   (w_msb),
        .last_o  (w_last)
    );

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        ch_ptr_d = ch_ptr_q;
        if (cs_i) begin
            state_d = IDLE;
            src_d   = SRC_REG;
        end else begin
            case (state_q)
                IDLE: begin
                    if (addr_valid_i) begin
                        if (w_is_ch) begin
                            state_d  = SHIFT;
                            src_d    = SRC_CH;
                            ch_ptr_d = w_addr_ch;
                        end else begin
                            src_d    = SRC_REG;
                        end
                    end
                end
                SHIFT: begin
                    if (w_last) begin
                        ch_ptr_d = w_ch_next;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge spi_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            src_q    <= SRC_REG;
            ch_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            ch_ptr_q <= ch_ptr_d;
        end
    end

    always_comb begin
        rd_ack_o = '0;
        if ((state_q == SHIFT) && w_last && !cs_i) begin
            rd_ack_o[ch_ptr_q] = 1'b1;
        end
    end

    assign busy_o = (state_q == SHIFT);
    assign poci_o = (src_q == SRC_CH) ? w_msb : poci_spi_i;

endmodule

`default_nettype wire

// File: tb/tb_psec6_readout_serializer.sv
// ============================================================================
// Module  : tb_psec6_readout_serializer
// Brief   : Directed self-checking bench for psec6_readout_serializer.
//           Honours PSEC6_READOUT_PARITY_EN for the expected word format.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_psec6_readout_serializer;

    localparam int NUM_CH = 8;
    localparam int WORD_W = 8;
`ifdef PSEC6_READOUT_PARITY_EN
    localparam int WP = WORD_W + 1;
`else
    localparam int WP = WORD_W;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     cs;
    logic [6:0]               addr;
    logic                     addr_valid;
    logic                     poci_spi;
    logic [NUM_CH*WORD_W-1:0] ch_data;
    logic                     poci;
    logic [NUM_CH-1:0]        rd_ack;
    logic                     busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    psec6_readout_serializer #(
        .NUM_CH (NUM_CH),
        .WORD_W (WORD_W)
    ) dut (
        .spi_clk_i    (clk),
        .rst_i        (rst),
        .cs_i         (cs),
        .addr_i       (addr),
        .addr_valid_i (addr_valid),
        .poci_spi_i   (poci_spi),
        .ch_data_i    (ch_data),
        .poci_o       (poci),
        .rd_ack_o     (rd_ack),
        .busy_o       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [WORD_W-1:0] w, input int i);
        if (i < WORD_W) return w[WORD_W-1-i];
        return ^w;
    endfunction

    // Issue an address strobe at a falling edge; returns at bit-0 of the word.
    task automatic start(input logic [6:0] a);
        cs = 1'b0; addr = a; addr_valid = 1'b1;
        @(negedge clk);
        addr_valid = 1'b0;
    endtask

    // Check n bit-cycles of word w from channel ch; ack expected on bit WP-1.
    task automatic run_bits(input int ch, input logic [WORD_W-1:0] w, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            #1;
            check($sformatf("%s_poci%0d", tag, i), 32'(poci), 32'(exp_bit(w, i)));
            check($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'd1);
            check($sformatf("%s_ack%0d", tag, i), 32'(rd_ack),
                  (i == WP - 1) ? (32'd1 << ch) : 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic end_cs(input string tag);
        cs = 1'b1;
        #1 check({tag, "_ack_cs"}, 32'(rd_ack), 32'd0);
        @(negedge clk);
        #1 check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; cs = 1'b1; addr = '0; addr_valid = 1'b0; poci_spi = 1'b0;
        ch_data = '0;
        ch_data[0*WORD_W +: WORD_W] = 8'h81;
        ch_data[1*WORD_W +: WORD_W] = 8'h5A;
        ch_data[2*WORD_W +: WORD_W] = 8'hC6;
        ch_data[3*WORD_W +: WORD_W] = 8'hA5;
        ch_data[4*WORD_W +: WORD_W] = 8'hF0;
        ch_data[7*WORD_W +: WORD_W] = 8'h3C;

        // Reset state
        @(negedge clk); @(negedge clk);
        poci_spi = 1'b1;
        #1 check("rst_poci", 32'(poci), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(rd_ack), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single word on ch3; ch_data change after load must not matter
        start(7'd19);
        ch_data[3*WORD_W +: WORD_W] = 8'h00;
        run_bits(3, 8'hA5, WP, "single");
        end_cs("single");
        ch_data[3*WORD_W +: WORD_W] = 8'hA5;

        // Reset asserted mid-word
        start(7'd19);
        run_bits(3, 8'hA5, 3, "rstmid");
        rst = 1'b1; poci_spi = 1'b0;
        #1 check("rstmid_poci0", 32'(poci), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_ack", 32'(rd_ack), 32'd0);
        @(negedge clk);
        poci_spi = 1'b1;
        #1 check("rstmid_poci1", 32'(poci), 32'd1);
        check("rstmid_hold_busy", 32'(busy), 32'd0);
        check("rstmid_hold_ack", 32'(rd_ack), 32'd0);
        rst = 1'b0; cs = 1'b1;
        @(negedge clk);

        // Burst with wrap ch7 -> ch0 -> ch1
        start(7'd23);
        run_bits(7, 8'h3C, WP, "burst7");
        run_bits(0, 8'h81, WP, "burst0");
        run_bits(1, 8'h5A, WP, "burst1");
        end_cs("burst");

        // Abort after 5 bits of ch2, then restart from its MSB
        start(7'd18);
        run_bits(2, 8'hC6, 5, "abort");
        end_cs("abort");
        @(negedge clk);
        start(7'd18);
        run_bits(2, 8'hC6, WP, "restart");
        end_cs("restart");

        // cs rising on the last-bit cycle suppresses rd_ack
        start(7'd18);
        run_bits(2, 8'hC6, WP - 1, "cswin");
        cs = 1'b1;
        #1 check("cswin_ack", 32'(rd_ack), 32'd0);
        @(negedge clk);
        #1 check("cswin_idle", 32'(busy), 32'd0);

        // Register passthrough
        start(7'd4);
        #1 check("reg_busy", 32'(busy), 32'd0);
        poci_spi = 1'b0;
        #1 check("reg_poci0", 32'(poci), 32'd0);
        poci_spi = 1'b1;
        #1 check("reg_poci1", 32'(poci), 32'd1);
        poci_spi = 1'b0;
        #1 check("reg_poci2", 32'(poci), 32'd0);
        @(negedge clk);

        // Address-map boundaries: 15 and 24 are register space, 30 too
        start(7'd15);
        #1 check("addr15_busy", 32'(busy), 32'd0);
        @(negedge clk);
        start(7'd24);
        #1 check("addr24_busy", 32'(busy), 32'd0);
        @(negedge clk);
        start(7'd30);
        poci_spi = 1'b1;
        #1 check("addr30_busy", 32'(busy), 32'd0);
        check("addr30_poci", 32'(poci), 32'd1);
        @(negedge clk);

        // addr 16 -> channel 0 with 8'h07 (parity bit 1 when enabled)
        ch_data[0*WORD_W +: WORD_W] = 8'h07;
        start(7'd16);
        run_bits(0, 8'h07, WP, "ch0");
        end_cs("ch0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
